// File: rtl/fir_decim_buffer.sv
// Decimating output buffer for the FIR filter: keeps every DECIM-th valid
// sample and queues it in a DEPTH-entry FIFO for a ready/valid consumer.
module fir_decim_buffer #(
    parameter int N     = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic [N-1:0]             Din,
    input  logic                     Din_valid,
    output logic [N-1:0]             Dout,
    output logic                     Dout_valid,
    input  logic                     Dout_ready,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0] r_phase;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic [N-1:0]    r_mem [DEPTH];

    logic            w_keep;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Keep decision: phase 0 marks the first sample of each decimation group
    assign w_keep = Din_valid && (r_phase == '0);
    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = (r_count != '0) && Dout_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge
    assign w_push = w_keep && (!w_full || w_pop);
    assign w_drop = w_keep && w_full && !w_pop;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (Din_valid) begin
                r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sample storage carries data only, so it is left out of reset
    always_ff @(posedge Clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= Din;
        end
    end

    assign Count      = r_count;
    assign Overflow   = r_overflow;
    assign Dout_valid = (r_count != '0);
    assign Dout       = Dout_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: one instance with DECIM=4 and one with DECIM=1,
// a behavioural FIFO model per instance plus fixed expected sequences.
module tb_fir_decim_buffer;

    logic        clk;
    logic        rst;

    logic [15:0] din4, dout4, din1, dout1;
    logic        vld4, rdy4, dvld4, ovf4;
    logic        vld1, rdy1, dvld1, ovf1;
    logic [3:0]  cnt4, cnt1;

    int total = 0;
    int bad   = 0;

    fir_decim_buffer #(.N(16), .DECIM(4), .DEPTH(8)) u_dut4 (
        .Clk(clk), .reset(rst), .Din(din4), .Din_valid(vld4),
        .Dout(dout4), .Dout_valid(dvld4), .Dout_ready(rdy4),
        .Count(cnt4), .Overflow(ovf4)
    );

    fir_decim_buffer #(.N(16), .DECIM(1), .DEPTH(8)) u_dut1 (
        .Clk(clk), .reset(rst), .Din(din1), .Din_valid(vld1),
        .Dout(dout1), .Dout_valid(dvld1), .Dout_ready(rdy1),
        .Count(cnt1), .Overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int q4[$];
    int q1[$];
    int ph4, ph1;
    bit mov4, mov1;
    int log4[$];
    int log1[$];

    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic        rdy;
        int          cnt;
        int          dout;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit v, input int d, input bit r, input int decim,
                              inout int q[$], inout int ph, inout bit ov);
        int  sz;
        bit  keep;
        bit  pop;
        sz   = q.size();
        pop  = (sz > 0) && r;
        keep = v && (ph == 0);
        if (v) ph = (ph + 1) % decim;
        if (pop) void'(q.pop_front());
        if (keep) begin
            if (sz < 8 || pop) q.push_back(d);
            else ov = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("count4", cnt4, q4.size());
        chk("dvld4", dvld4, q4.size() != 0);
        chk("dout4", dout4, (q4.size() != 0) ? q4[0] : 0);
        chk("ovf4", ovf4, mov4);
        chk("count1", cnt1, q1.size());
        chk("dvld1", dvld1, q1.size() != 0);
        chk("dout1", dout1, (q1.size() != 0) ? q1[0] : 0);
        chk("ovf1", ovf1, mov1);
    endtask

    // One clock: log observed pops, advance the model on the edge, compare after it
    task automatic tick();
        if (!rst) begin
            if (dvld4 === 1'b1 && rdy4) log4.push_back(int'(dout4));
            if (dvld1 === 1'b1 && rdy1) log1.push_back(int'(dout1));
        end
        @(posedge clk);
        if (rst) begin
            q4.delete(); q1.delete();
            ph4 = 0; ph1 = 0;
            mov4 = 1'b0; mov1 = 1'b0;
        end else begin
            model_step(vld4, int'(din4), rdy4, 4, q4, ph4, mov4);
            model_step(vld1, int'(din1), rdy1, 1, q1, ph1, mov1);
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        vld4 = 1'b0; din4 = '0; rdy4 = 1'b0;
        vld1 = 1'b0; din1 = '0; rdy1 = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log4.delete();
        log1.delete();
    endtask

    initial begin
        int max_cnt;
        ph4 = 0; ph1 = 0; mov4 = 0; mov1 = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_count4", cnt4, 0);
        chk("reset_dout4", dout4, 0);
        chk("reset_ovf1", ovf1, 0);
        rst = 1'b0;

        // Basic decimation by 4 with a always-ready consumer
        for (int i = 0; i < 12; i++) begin
            tbl[i].vld  = 1'b1;
            tbl[i].din  = 16'(i + 1);
            tbl[i].rdy  = 1'b1;
            tbl[i].cnt  = (i % 4 == 0) ? 1 : 0;
            tbl[i].dout = (i % 4 == 0) ? i + 1 : 0;
        end
        for (int i = 0; i < 12; i++) begin
            vld4 = tbl[i].vld; din4 = tbl[i].din; rdy4 = tbl[i].rdy;
            tick();
            chk($sformatf("tbl_count[%0d]", i), cnt4, tbl[i].cnt);
            chk($sformatf("tbl_dout[%0d]", i), dout4, tbl[i].dout);
        end
        idle(); rdy4 = 1'b1;
        tick();
        chk("basic_n", log4.size(), 3);
        if (log4.size() == 3) begin
            chk("basic_0", log4[0], 1);
            chk("basic_1", log4[1], 5);
            chk("basic_2", log4[2], 9);
        end

        // Gapped valid: phase holds across idle cycles
        log4.delete();
        for (int i = 0; i < 9; i++) begin
            vld4 = (i % 2 == 0);
            din4 = (i % 2 == 0) ? 16'(10 * (i / 2 + 1)) : 16'd0;
            rdy4 = 1'b1;
            tick();
        end
        idle(); rdy4 = 1'b1;
        tick();
        chk("gap_n", log4.size(), 2);
        if (log4.size() == 2) begin
            chk("gap_0", log4[0], 10);
            chk("gap_1", log4[1], 50);
        end

        // Mid-stream reset with a partly full FIFO and Overflow set
        for (int i = 0; i < 37; i++) begin
            vld4 = 1'b1; din4 = 16'(1000 + i); rdy4 = 1'b0;
            tick();
        end
        chk("mid_full", cnt4, 8);
        chk("mid_ovf", ovf4, 1);
        idle(); rdy4 = 1'b1;
        repeat (3) tick();
        chk("mid_count5", cnt4, 5);
        do_reset();
        chk("rst_count", cnt4, 0);
        chk("rst_dvld", dvld4, 0);
        chk("rst_dout", dout4, 0);
        chk("rst_ovf", ovf4, 0);
        vld4 = 1'b1; din4 = 16'd77; rdy4 = 1'b1;
        tick();
        chk("post_rst_dout", dout4, 77);
        idle(); rdy4 = 1'b1;
        tick();
        chk("post_rst_log", (log4.size() == 1) ? log4[0] : -1, 77);

        // Fill past full with DECIM=1 and no consumer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            vld1 = 1'b1; din1 = 16'(100 + i); rdy1 = 1'b0;
            tick();
            if (i == 7) chk("fill8_ovf", ovf1, 0);
            if (i == 8) begin
                chk("fill9_ovf", ovf1, 1);
                chk("fill9_count", cnt1, 8);
            end
        end
        idle(); rdy1 = 1'b1;
        repeat (9) tick();
        chk("drain_ovf_sticky", ovf1, 1);
        chk("drain_n", log1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log1.size()) chk($sformatf("drain[%0d]", i), log1[i], 100 + i);
        end

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vld1 = 1'b1; din1 = 16'(200 + i); rdy1 = 1'b0;
            tick();
        end
        vld1 = 1'b1; din1 = 16'd55; rdy1 = 1'b1;
        tick();
        chk("fullpp_count", cnt1, 8);
        chk("fullpp_ovf", ovf1, 0);
        idle(); rdy1 = 1'b1;
        repeat (9) tick();
        chk("fullpp_n", log1.size(), 9);
        if (log1.size() == 9) begin
            chk("fullpp_head", log1[0], 200);
            chk("fullpp_last_old", log1[7], 207);
            chk("fullpp_55", log1[8], 55);
        end

        // Pointer wrap with an always-ready consumer
        do_reset();
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            vld1 = 1'b1; din1 = 16'(i); rdy1 = 1'b1;
            tick();
            if (i == 0) chk("nobypass_count", cnt1, 1);
            if (int'(cnt1) > max_cnt) max_cnt = int'(cnt1);
        end
        idle(); rdy1 = 1'b1;
        tick();
        chk("wrap_maxcnt", max_cnt, 1);
        chk("wrap_ovf", ovf1, 0);
        chk("wrap_n", log1.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < log1.size()) chk($sformatf("wrap[%0d]", i), log1[i], i);
        end

        // Empty FIFO with a ready consumer stays empty
        idle(); rdy1 = 1'b1; rdy4 = 1'b1;
        tick();
        chk("empty_ready", cnt1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
